sdp_ram_stream: RTL and testbench
=================================

SDP_RAM_STREAM -- requirements
Module: sdp_ram_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, read/write data width in bits; must be a multiple of BYTE_W.
REQ-002 SHALL have parameter ADDR_W, default 14, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter BYTE_W, default 8, bits per write-enable lane; NBE = DATA_W/BYTE_W lanes.
REQ-004 SHALL have parameter WRITE_FIRST, default 0, collision mode: 0 = old data, 1 = new data.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-009 SHALL have port wr_be, input, NBE, per-lane write enable.
REQ-010 SHALL have port wr_data, input, DATA_W, write data.
REQ-011 SHALL have port rd_req_valid, input, 1, read request offered.
REQ-012 SHALL have port rd_req_ready, output, 1, read request accepted this cycle if valid.
REQ-013 SHALL have port rd_addr, input, ADDR_W, read address, sampled on acceptance.
REQ-014 SHALL have port rd_valid, output, 1, rd_data holds a read response.
REQ-015 SHALL have port rd_ready, input, 1, consumer takes the response.
REQ-016 SHALL have port rd_data, output, DATA_W, read response data.

Function
REQ-017 SHALL write lane i of mem[wr_addr] at posedge when wr_en && wr_be[i]; lanes with wr_be[i]=0 stay unchanged; no write handshake.
REQ-018 SHALL accept a read when rd_req_valid && rd_req_ready; responses return in acceptance order.
REQ-019 SHALL raise rd_valid with the accepted word exactly L cycles after acceptance when not stalled; L=1 without output register, L=2 with it.
REQ-020 SHALL keep rd_data and rd_valid stable while rd_valid && !rd_ready; the response is dropped only on rd_valid && rd_ready.
REQ-021 SHALL drive rd_req_ready = 1 iff in-flight reads + buffered responses < 2 (3 with output register), so no response is ever lost under backpressure.
REQ-022 SHALL sustain one read per cycle while rd_ready stays 1.
REQ-023 Collision (write and accepted read, same address, same cycle): WRITE_FIRST=0 returns pre-write word; WRITE_FIRST=1 returns the word merged with wr_data on enabled lanes.
REQ-024 SHALL return for a read accepted the cycle after a write the written data, regardless of WRITE_FIRST.
REQ-025 SHALL ignore rd_addr when no request is accepted and wr_addr/wr_data when wr_en=0.

Reset
REQ-026 SHALL, while rst_n=0, force rd_valid=0, rd_data=0, rd_req_ready=0, buffer empty, no in-flight reads.
REQ-027 SHALL drive rd_req_ready=1 in the first cycle after rst_n deasserts.
REQ-028 SHALL discard in-flight and buffered reads on reset mid-operation; no stale rd_valid after release.
REQ-029 SHALL NOT reset memory contents; writes during reset are ignored.

Configuration
REQ-030 Macro SDP_RAM_STREAM_OUTREG_EN defined: extra register after array read, L=2, buffer depth 3.
REQ-031 Macro undefined: no output register, L=1, buffer depth 2; all other behaviour identical.

Structure
REQ-032 Package sdp_ram_pkg SHALL hold default DATA_W/ADDR_W/BYTE_W and the collision-mode constants (COLL_OLD=0, COLL_NEW=1).
REQ-033 Output buffering SHALL be one sub-module sdp_ram_skid (parametrised-depth valid/ready FIFO with occupancy count); the array and collision logic stay in the top.

Verification
REQ-034 Write 0xA5 to addr 0x0010, read addr 0x0010 next cycle, rd_ready=1 -> rd_valid after L cycles, rd_data=0xA5.
REQ-035 DATA_W=32: mem[3]=0x11223344, write wr_be=4'b0101 data 0xAABBCCDD -> read returns 0x11BB33DD.
REQ-036 Same-cycle write 0x77 / read addr 5 (old 0x12) -> WRITE_FIRST=0 returns 0x12; WRITE_FIRST=1 returns 0x77.
REQ-037 Back-to-back reads addrs 0..7, rd_ready low cycles 3-6 -> rd_req_ready falls at buffer limit, all 8 words delivered in order, no duplicates.
REQ-038 rst_n pulsed low with 2 reads in flight -> rd_valid=0 during and after reset until a new read; rd_req_ready=1 one cycle after release.
REQ-039 Continuous reads, rd_ready=1, both macro settings -> one response per cycle, latency 1 vs 2.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared defaults, collision-mode encodings and sizing helper for the streaming simple-dual-port RAM.
package sdp_ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_BYTE_W = 8;

  localparam int COLL_OLD = 0;
  localparam int COLL_NEW = 1;

  // Bits needed to count 0..depth entries inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sdp_ram_skid.sv
// Response FIFO with fall-through bypass: latency 0 when empty, holds data stable while i_out_rdy is low.
// Never refuses a push; the producer must limit outstanding entries to DEPTH using o_count.
module sdp_ram_skid
  import sdp_ram_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = 2,
  parameter int CW    = occ_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_vld,
  input  logic [W-1:0]  i_in_dat,
  output logic          o_out_vld,
  input  logic          i_out_rdy,
  output logic [W-1:0]  o_out_dat,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  r_buf [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_empty   = (r_cnt == '0);
  assign w_pop     = !w_empty && i_out_rdy;
  // An arriving word consumed straight through the bypass is never stored.
  assign w_push    = i_in_vld && !(w_empty && i_out_rdy);
  assign o_out_vld = !w_empty || i_in_vld;
  assign o_out_dat = !o_out_vld ? '0 : (w_empty ? i_in_dat : r_buf[r_rptr]);
  assign o_count   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wptr] <= i_in_dat;
  end

endmodule

// File: rtl/sdp_ram_stream.sv
// Byte-lane simple-dual-port RAM with a valid/ready read stream; latency 1, or 2 with SDP_RAM_STREAM_OUTREG_EN.
// Read acceptance is credit-limited to the response buffer depth so rd_ready backpressure never loses data.
module sdp_ram_stream
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BYTE_W      = DEF_BYTE_W,
  parameter int WRITE_FIRST = COLL_OLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int NBE = DATA_W / BYTE_W;
`ifdef SDP_RAM_STREAM_OUTREG_EN
  localparam int BUF_DEPTH = 3;
`else
  localparam int BUF_DEPTH = 2;
`endif
  localparam int CW = occ_w(BUF_DEPTH);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_wdat_q;
  logic [NBE-1:0]    r_wbe_q;
  logic              r_s1_vld;
  logic              r_coll;
  logic [DATA_W-1:0] w_s1_dat;
  logic              w_we;
  logic              w_acc;
  logic              w_push_vld;
  logic [DATA_W-1:0] w_push_dat;
  logic [CW-1:0]     w_buf_cnt;
  logic [2:0]        w_used;

  assign w_we  = wr_en && rst_n;
  assign w_acc = rd_req_valid && rd_req_ready;

  // Array has no reset; a same-cycle read sees the pre-write word here.
  always_ff @(posedge clk) begin
    if (w_acc) r_ram_q <= r_mem[rd_addr];
    for (int i = 0; i < NBE; i++) begin
      if (w_we && wr_be[i]) r_mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_coll   <= 1'b0;
      r_wbe_q  <= '0;
      r_wdat_q <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_coll   <= (WRITE_FIRST == COLL_NEW) && w_acc && wr_en && (wr_addr == rd_addr);
      r_wbe_q  <= wr_be;
      r_wdat_q <= wr_data;
    end
  end

  // New-data collisions patch the enabled lanes over the pre-write word.
  always_comb begin
    w_s1_dat = r_ram_q;
    if (r_coll) begin
      for (int i = 0; i < NBE; i++) begin
        if (r_wbe_q[i]) w_s1_dat[i*BYTE_W +: BYTE_W] = r_wdat_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef SDP_RAM_STREAM_OUTREG_EN
  logic              r_s2_vld;
  logic [DATA_W-1:0] r_s2_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_dat <= w_s1_dat;
    end
  end

  assign w_push_vld = r_s2_vld;
  assign w_push_dat = r_s2_dat;
  assign w_used     = 3'(w_buf_cnt) + {2'b00, r_s1_vld} + {2'b00, r_s2_vld};
`else
  assign w_push_vld = r_s1_vld;
  assign w_push_dat = w_s1_dat;
  assign w_used     = 3'(w_buf_cnt) + {2'b00, r_s1_vld};
`endif

  assign rd_req_ready = rst_n && (w_used < 3'(BUF_DEPTH));

  sdp_ram_skid #(
    .W     (DATA_W),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_in_vld  (w_push_vld),
    .i_in_dat  (w_push_dat),
    .o_out_vld (rd_valid),
    .i_out_rdy (rd_ready),
    .o_out_dat (rd_data),
    .o_count   (w_buf_cnt)
  );

endmodule

// File: tb/tb_sdp_ram_stream.sv
// Directed bench: two instances (old-data and new-data collision) share stimulus; table vectors plus
// stream, backpressure and mid-operation reset sequences.
module tb_sdp_ram_stream;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NBE = 4;
`ifdef SDP_RAM_STREAM_OUTREG_EN
  localparam int LAT = 2, DEPTH = 3;
`else
  localparam int LAT = 1, DEPTH = 2;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [NBE-1:0] wr_be;
  logic [DW-1:0]  wr_data;
  logic           rd_req_valid;
  logic [AW-1:0]  rd_addr;
  logic           rd_ready;
  logic [1:0]     rq_rdy;
  logic [1:0]     rvld;
  logic [DW-1:0]  rdat [2];

  always #5 clk = ~clk;

  sdp_ram_stream #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .WRITE_FIRST(0)) u_old (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rq_rdy[0]), .rd_addr(rd_addr),
    .rd_valid(rvld[0]), .rd_ready(rd_ready), .rd_data(rdat[0]));

  sdp_ram_stream #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .WRITE_FIRST(1)) u_new (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rq_rdy[1]), .rd_addr(rd_addr),
    .rd_valid(rvld[1]), .rd_ready(rd_ready), .rd_data(rdat[1]));

  typedef struct {
    logic           we;
    logic [AW-1:0]  wa;
    logic [NBE-1:0] be;
    logic [DW-1:0]  wd;
    logic           rd;
    logic [AW-1:0]  ra;
    logic [DW-1:0]  e_old;
    logic [DW-1:0]  e_new;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of write and/or read request; a read waits for its response and checks latency and data.
  task automatic apply(input vec_t v, input string nm);
    int c;
    bit got;
    wr_en = v.we; wr_addr = v.wa; wr_be = v.be; wr_data = v.wd;
    rd_req_valid = v.rd; rd_addr = v.ra; rd_ready = 1'b1;
    @(negedge clk);
    if (v.rd) chk({nm, "_rdy"}, 32'(rq_rdy[0]), 32'd1);
    tick();
    idle_inputs();
    if (v.rd) begin
      c = 0;
      got = 1'b0;
      while (!got && c < LAT + 3) begin
        @(negedge clk);
        c++;
        if (rvld[0]) begin
          got = 1'b1;
          chk({nm, "_lat"}, 32'(c), 32'(LAT));
          chk({nm, "_old"}, rdat[0], v.e_old);
          chk({nm, "_new"}, rdat[1], v.e_new);
          chk({nm, "_vld_new"}, 32'(rvld[1]), 32'd1);
        end
        tick();
      end
      chk({nm, "_got"}, 32'(got), 32'd1);
    end
  endtask

  function automatic vec_t mkw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    vec_t v;
    v = '{1'b1, a, 4'hF, d, 1'b0, 8'h00, 32'h0, 32'h0};
    return v;
  endfunction

  // Reads addrs 0..7 (preloaded 0x100+i); optional rd_ready stall on cycles 3-6.
  task automatic run_stream(input bit stall);
    int acc, del, cyc, first, last;
    int acc_cyc [8];
    bit saw_low, prev_hold;
    logic [DW-1:0] prev_dat;
    acc = 0; del = 0; cyc = 0; first = -1; last = -1;
    saw_low = 1'b0; prev_hold = 1'b0; prev_dat = '0;
    while (del < 8 && cyc < 60) begin
      rd_req_valid = (acc < 8);
      rd_addr = AW'(acc);
      rd_ready = !(stall && cyc >= 3 && cyc <= 6);
      @(negedge clk);
      chk("str_rdy", 32'(rq_rdy[0]), 32'((acc - del) < DEPTH));
      if (!rq_rdy[0]) saw_low = 1'b1;
      if (prev_hold) begin
        chk("str_hold_vld", 32'(rvld[0]), 32'd1);
        chk("str_hold_dat", rdat[0], prev_dat);
      end
      if (rvld[0] && rd_ready) begin
        chk("str_dat_old", rdat[0], 32'h100 + 32'(del));
        chk("str_dat_new", rdat[1], 32'h100 + 32'(del));
        if (!stall) chk("str_lat", 32'(cyc - acc_cyc[del]), 32'(LAT));
        if (first < 0) first = cyc;
        last = cyc;
        del++;
      end
      prev_hold = rvld[0] && !rd_ready;
      prev_dat = rdat[0];
      if (rd_req_valid && rq_rdy[0]) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      tick();
      cyc++;
    end
    idle_inputs();
    chk("str_count", 32'(del), 32'd8);
    if (stall) chk("str_backpressure", 32'(saw_low), 32'd1);
    else       chk("str_rate", 32'(last - first), 32'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    //         we    wa     be    wd             rd    ra     old            new
    vt[0]  = '{1'b1, 8'h10, 4'hF, 32'h000000A5, 1'b0, 8'h00, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 8'h00, 4'h0, 32'h0,        1'b1, 8'h10, 32'h000000A5, 32'h000000A5};
    vt[2]  = '{1'b1, 8'h03, 4'hF, 32'h11223344, 1'b0, 8'h00, 32'h0,        32'h0};
    vt[3]  = '{1'b1, 8'h03, 4'h5, 32'hAABBCCDD, 1'b0, 8'h00, 32'h0,        32'h0};
    vt[4]  = '{1'b0, 8'h00, 4'h0, 32'h0,        1'b1, 8'h03, 32'h11BB33DD, 32'h11BB33DD};
    vt[5]  = '{1'b1, 8'h05, 4'hF, 32'h00000012, 1'b0, 8'h00, 32'h0,        32'h0};
    vt[6]  = '{1'b1, 8'h05, 4'hF, 32'h00000077, 1'b1, 8'h05, 32'h00000012, 32'h00000077};
    vt[7]  = '{1'b0, 8'h00, 4'h0, 32'h0,        1'b1, 8'h05, 32'h00000077, 32'h00000077};
    vt[8]  = '{1'b1, 8'h09, 4'hF, 32'hCAFEF00D, 1'b0, 8'h00, 32'h0,        32'h0};
    vt[9]  = '{1'b1, 8'h09, 4'hC, 32'h12345678, 1'b1, 8'h09, 32'hCAFEF00D, 32'h1234F00D};
    vt[10] = '{1'b0, 8'h00, 4'h0, 32'h0,        1'b1, 8'h09, 32'h1234F00D, 32'h1234F00D};
    vt[11] = '{1'b0, 8'h09, 4'hF, 32'hFFFFFFFF, 1'b1, 8'h09, 32'h1234F00D, 32'h1234F00D};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_vld", 32'(rvld[0]), 32'd0);
    chk("rst_dat", rdat[0], 32'd0);
    chk("rst_rdy_old", 32'(rq_rdy[0]), 32'd0);
    chk("rst_rdy_new", 32'(rq_rdy[1]), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy_old", 32'(rq_rdy[0]), 32'd1);
    chk("rel_rdy_new", 32'(rq_rdy[1]), 32'd1);
    tick();

    for (int v = 0; v < NV; v++) apply(vt[v], $sformatf("vec%0d", v));

    for (int i = 0; i < 8; i++) apply(mkw(AW'(i), 32'h100 + 32'(i)), "preload");
    run_stream(1'b0);
    run_stream(1'b1);

    // Two reads parked under backpressure, then reset with a write attempt to 0x10.
    rd_ready = 1'b0;
    rd_req_valid = 1'b1;
    rd_addr = 8'h00;
    @(negedge clk);
    chk("rm_rdy_a", 32'(rq_rdy[0]), 32'd1);
    tick();
    rd_addr = 8'h01;
    @(negedge clk);
    chk("rm_rdy_b", 32'(rq_rdy[0]), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    @(negedge clk);
    chk("rm_pending_vld", 32'(rvld[0]), 32'd1);
    tick();
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 8'h10; wr_be = 4'hF; wr_data = 32'h0000DEAD;
    repeat (2) begin
      @(negedge clk);
      chk("rm_in_vld", 32'(rvld[0]), 32'd0);
      chk("rm_in_dat", rdat[0], 32'd0);
      chk("rm_in_rdy", 32'(rq_rdy[0]), 32'd0);
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    repeat (3) begin
      @(negedge clk);
      chk("rm_post_vld_old", 32'(rvld[0]), 32'd0);
      chk("rm_post_vld_new", 32'(rvld[1]), 32'd0);
      chk("rm_post_rdy", 32'(rq_rdy[0]), 32'd1);
      tick();
    end
    apply('{1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 8'h10, 32'h000000A5, 32'h000000A5}, "rm_mem_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
